// File: rtl/xbar_txn_tracker.sv
// Per-master transaction-ordering tracker for the crossbar master-side port.
// Keeps per-ID outstanding counters and destination slaves for AR and AW,
// gates issue so same-ID traffic stays on one slave, and queues AW
// destinations so W beats are steered to the right slave.
// Optional build macro: XBAR_TRACKER_ERR_EN adds the sticky err_unmatched output.
module xbar_txn_tracker #(
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned slaves          = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned W_QUEUE_DEPTH   = 4,
  localparam int unsigned SW = (slaves > 1) ? $clog2(slaves) : 1,
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                ar_req_valid,
  input  logic [ID_WIDTH-1:0] ar_req_id,
  input  logic [SW-1:0]       ar_req_dest,
  output logic                ar_allow,
  input  logic                ar_issue,
  input  logic                r_done,
  input  logic [ID_WIDTH-1:0] r_done_id,
  input  logic                aw_req_valid,
  input  logic [ID_WIDTH-1:0] aw_req_id,
  input  logic [SW-1:0]       aw_req_dest,
  output logic                aw_allow,
  input  logic                aw_issue,
  input  logic                b_done,
  input  logic [ID_WIDTH-1:0] b_done_id,
  output logic                w_dest_valid,
  output logic [SW-1:0]       w_dest,
  input  logic                w_last_fire
`ifdef XBAR_TRACKER_ERR_EN
  ,
  output logic                err_unmatched
`endif
);

  localparam int unsigned NID = 2 ** ID_WIDTH;
  localparam int unsigned QW  = $clog2(W_QUEUE_DEPTH);
  localparam int unsigned QCW = $clog2(W_QUEUE_DEPTH + 1);
  localparam logic [CW-1:0]  CntMax = CW'(MAX_OUTSTANDING);
  localparam logic [QCW-1:0] QFull  = QCW'(W_QUEUE_DEPTH);

  logic [NID-1:0][CW-1:0] ar_cnt_q, ar_cnt_d, aw_cnt_q, aw_cnt_d;
  logic [NID-1:0][SW-1:0] ar_dst_q, ar_dst_d, aw_dst_q, aw_dst_d;

  logic [W_QUEUE_DEPTH-1:0][SW-1:0] wq_mem_q;
  logic [QW-1:0]                    wq_wr_q, wq_rd_q;
  logic [QCW-1:0]                   wq_cnt_q;

  logic ar_fire, aw_fire, ar_dec, aw_dec;
  logic wq_push, wq_pop, wq_full, wq_empty;

  // Issue gating: free ID, or same slave with room left.
  always_comb begin
    wq_empty = (wq_cnt_q == '0);
    wq_full  = (wq_cnt_q == QFull);
    ar_allow = ar_req_valid &
               ((ar_cnt_q[ar_req_id] == '0) |
                ((ar_cnt_q[ar_req_id] < CntMax) & (ar_dst_q[ar_req_id] == ar_req_dest)));
    aw_allow = aw_req_valid & ~wq_full &
               ((aw_cnt_q[aw_req_id] == '0) |
                ((aw_cnt_q[aw_req_id] < CntMax) & (aw_dst_q[aw_req_id] == aw_req_dest)));
    ar_fire  = ar_issue & ar_allow;
    aw_fire  = aw_issue & aw_allow;
    ar_dec   = r_done & (ar_cnt_q[r_done_id] != '0);
    aw_dec   = b_done & (aw_cnt_q[b_done_id] != '0);
    wq_push  = aw_fire;
    wq_pop   = w_last_fire & ~wq_empty;
    w_dest_valid = ~wq_empty;
    w_dest       = wq_empty ? '0 : wq_mem_q[wq_rd_q];
  end

  // AR table update: retire first, then issue, so a same-ID retire+issue at
  // count 1 passes through zero and reloads the destination.
  always_comb begin
    ar_cnt_d = ar_cnt_q;
    ar_dst_d = ar_dst_q;
    if (ar_dec) ar_cnt_d[r_done_id] = ar_cnt_q[r_done_id] - CW'(1);
    if (ar_fire) begin
      if (ar_cnt_d[ar_req_id] == '0) ar_dst_d[ar_req_id] = ar_req_dest;
      ar_cnt_d[ar_req_id] = ar_cnt_d[ar_req_id] + CW'(1);
    end
  end

  // AW table update, same ordering as the AR table.
  always_comb begin
    aw_cnt_d = aw_cnt_q;
    aw_dst_d = aw_dst_q;
    if (aw_dec) aw_cnt_d[b_done_id] = aw_cnt_q[b_done_id] - CW'(1);
    if (aw_fire) begin
      if (aw_cnt_d[aw_req_id] == '0) aw_dst_d[aw_req_id] = aw_req_dest;
      aw_cnt_d[aw_req_id] = aw_cnt_d[aw_req_id] + CW'(1);
    end
  end

  // Table and W-queue pointer state.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ar_cnt_q <= '0;
      ar_dst_q <= '0;
      aw_cnt_q <= '0;
      aw_dst_q <= '0;
      wq_wr_q  <= '0;
      wq_rd_q  <= '0;
      wq_cnt_q <= '0;
    end else begin
      ar_cnt_q <= ar_cnt_d;
      ar_dst_q <= ar_dst_d;
      aw_cnt_q <= aw_cnt_d;
      aw_dst_q <= aw_dst_d;
      if (wq_push) wq_wr_q <= wq_wr_q + QW'(1);
      if (wq_pop)  wq_rd_q <= wq_rd_q + QW'(1);
      case ({wq_push, wq_pop})
        2'b10:   wq_cnt_q <= wq_cnt_q + QCW'(1);
        2'b01:   wq_cnt_q <= wq_cnt_q - QCW'(1);
        default: wq_cnt_q <= wq_cnt_q;
      endcase
    end
  end

  // W-queue storage; contents are masked by w_dest_valid so no reset needed.
  always_ff @(posedge ACLK) begin
    if (wq_push) wq_mem_q[wq_wr_q] <= aw_req_dest;
  end

`ifdef XBAR_TRACKER_ERR_EN
  logic err_q;

  // Sticky flag for responses or WLASTs that match nothing in flight.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      err_q <= 1'b0;
    end else if ((r_done & (ar_cnt_q[r_done_id] == '0)) |
                 (b_done & (aw_cnt_q[b_done_id] == '0)) |
                 (w_last_fire & wq_empty)) begin
      err_q <= 1'b1;
    end
  end

  assign err_unmatched = err_q;
`endif

endmodule
